// File: rtl/ps2_host_tx_pkg.sv
// ps2_pkg: register map, STAT bit positions, transmitter FSM states and
// the PS/2 odd-parity helper. Shared by the host transmitter and the
// keyboard receiver.
package ps2_pkg;

  // APB byte offsets
  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_STAT   = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;

  // STAT bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ACK_ERR = 2;
  localparam int STAT_TIMEOUT = 3;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  // PS/2 frames carry odd parity over the 8 data bits
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// APB4 slave bundle for the PS/2 host transmitter register block.
interface ps2_host_tx_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ps2_host_tx_sync.sv
// ps2_sync: brings the asynchronous PS/2 pad levels into the system clock
// domain. Clock uses three flops so a falling-edge pulse can be taken from
// the last two without metastability exposure; data uses two flops.
// Flops reset to 1 (idle bus level) so reset release never fakes an edge.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_pad,
  input  logic dat_pad,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fall
);
  logic [2:0] clk_q;
  logic [1:0] dat_q;

  // synchronizer chains
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_q <= 3'b111;
      dat_q <= 2'b11;
    end else begin
      clk_q <= {clk_q[1:0], clk_pad};
      dat_q <= {dat_q[0], dat_pad};
    end
  end

  assign clk_s    = clk_q[2];
  assign dat_s    = dat_q[1];
  assign clk_fall = clk_q[2] & ~clk_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: APB-programmed PS/2 host-to-device transmitter.
// Performs inhibit / request-to-send, shifts a byte plus odd parity out on
// device clock falling edges, releases for the stop bit and checks the
// device ACK. Pads are driven only via active-high pull-low enables.
// Optional build macro PS2_HOST_TX_TIMEOUT_EN adds an abort timer covering
// SEND and ACK; without it the FSM waits indefinitely for the device.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic          hclk,
  input  logic          hrst,
  ps2_host_tx_if.slave  apb,
  input  logic          ps2_clk_i,
  input  logic          ps2_dat_i,
  output logic          ps2_clk_oe_o,
  output logic          ps2_dat_oe_o,
  output logic          irq_o
);
  localparam int IW = $clog2(INHIBIT_CYC + 1);

  state_t state, state_n;

  logic clk_s, dat_s, clk_fall;
  logic [7:0]    tx_byte;
  logic          tx_par;
  logic [IW-1:0] inh_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   frame;
  logic          done, ack_err, timeout, irq_en;
  logic          set_done, set_ack_err, tmo_hit;
  logic          acc, wr, rd, tx_wr, stat_w1c, ctrl_wr, busy;

  ps2_sync u_sync (
    .clk      (hclk),
    .rst      (hrst),
    .clk_pad  (ps2_clk_i),
    .dat_pad  (ps2_dat_i),
    .clk_s    (clk_s),
    .dat_s    (dat_s),
    .clk_fall (clk_fall)
  );

  // APB decode
  assign acc      = apb.psel & apb.penable;
  assign wr       = acc & apb.pwrite;
  assign rd       = acc & ~apb.pwrite;
  assign busy     = (state != IDLE);
  assign tx_wr    = wr & (apb.paddr == REG_TXDATA) & ~busy;
  assign stat_w1c = wr & (apb.paddr == REG_STAT);
  assign ctrl_wr  = wr & (apb.paddr == REG_CTRL);

  assign apb.pready  = 1'b1;
  assign apb.pslverr = wr & (apb.paddr == REG_TXDATA) & busy;

  // read mux, zero outside a read access
  always_comb begin
    apb.prdata = '0;
    if (rd) begin
      case (apb.paddr)
        REG_STAT: begin
          apb.prdata[STAT_BUSY]    = busy;
          apb.prdata[STAT_DONE]    = done;
          apb.prdata[STAT_ACK_ERR] = ack_err;
          apb.prdata[STAT_TIMEOUT] = timeout;
        end
        REG_CTRL: apb.prdata[0] = irq_en;
        default:  apb.prdata = '0;
      endcase
    end
  end

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // cycles since RTS exit; saturates so it never wraps back into range
  always_ff @(posedge hclk) begin
    if (hrst)
      tmo_cnt <= '0;
    else if (state == RTS)
      tmo_cnt <= '0;
    else if (tmo_cnt != TW'(TIMEOUT_CYC - 1))
      tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = ((state == SEND) || (state == ACK)) &&
                   (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif

  // start bit at index 0, data LSB first, parity, then ones (released)
  assign frame = {6'h3F, tx_par, tx_byte, 1'b0};

  // FSM state register
  always_ff @(posedge hclk) begin
    if (hrst) state <= IDLE;
    else      state <= state_n;
  end

  // FSM next state and pad enables
  always_comb begin
    state_n      = state;
    ps2_clk_oe_o = 1'b0;
    ps2_dat_oe_o = 1'b0;
    set_done     = 1'b0;
    set_ack_err  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_wr) state_n = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe_o = 1'b1;
        if (inh_cnt == IW'(INHIBIT_CYC - 1)) state_n = RTS;
      end
      RTS: begin
        ps2_clk_oe_o = 1'b1;
        ps2_dat_oe_o = 1'b1;
        state_n      = SEND;
      end
      SEND: begin
        // bit_cnt = falling edges seen so far; value 0 keeps the start bit
        ps2_dat_oe_o = ~frame[bit_cnt];
        if (clk_fall && bit_cnt == 4'd9) state_n = ACK;
      end
      ACK: begin
        if (clk_fall) begin
          set_ack_err = dat_s;
          state_n     = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          set_done = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (tmo_hit) state_n = IDLE;
  end

  // datapath: byte latch, inhibit timer, edge counter
  always_ff @(posedge hclk) begin
    if (hrst) begin
      tx_byte <= '0;
      tx_par  <= 1'b0;
      inh_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (tx_wr) begin
        tx_byte <= apb.pwdata[7:0];
        tx_par  <= odd_parity(apb.pwdata[7:0]);
        inh_cnt <= '0;
        bit_cnt <= '0;
      end
      if (state == INHIBIT) inh_cnt <= inh_cnt + IW'(1);
      if (state == SEND && clk_fall) bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // status flags (W1C, hardware set wins), CTRL and registered irq
  always_ff @(posedge hclk) begin
    if (hrst) begin
      done    <= 1'b0;
      ack_err <= 1'b0;
      timeout <= 1'b0;
      irq_en  <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      done    <= set_done    | (done    & ~(stat_w1c & apb.pwdata[STAT_DONE]));
      ack_err <= set_ack_err | (ack_err & ~(stat_w1c & apb.pwdata[STAT_ACK_ERR]));
      timeout <= tmo_hit     | (timeout & ~(stat_w1c & apb.pwdata[STAT_TIMEOUT]));
      if (ctrl_wr) irq_en <= apb.pwdata[0];
      irq_o   <= irq_en & (done | ack_err | timeout);
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, apb.pwdata[31:8]};

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device that
// clocks the frame, samples bits on rising edges and returns ACK/NACK.
module tb_ps2_host_tx;
  localparam int INH  = 5000;
  localparam int TMO  = 1000;
  localparam int HALF = 20;   // device clock half period in hclk cycles

  logic hclk = 1'b0;
  logic hrst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic ps2_clk, ps2_dat, clk_oe, dat_oe, irq;

  int checks = 0;
  int errors = 0;

  ps2_host_tx_if apb ();

  assign ps2_clk = ~clk_oe & dev_clk;
  assign ps2_dat = ~dat_oe & dev_dat;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .hclk         (hclk),
    .hrst         (hrst),
    .apb          (apb),
    .ps2_clk_i    (ps2_clk),
    .ps2_dat_i    (ps2_dat),
    .ps2_clk_oe_o (clk_oe),
    .ps2_dat_oe_o (dat_oe),
    .irq_o        (irq)
  );

  always #10 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  // entered #1 after a rising edge; returns #1 after the access edge
  task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic err);
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.paddr = a; apb.pwdata = d;
    @(posedge hclk); #1;
    apb.penable = 1'b1;
    #1 err = apb.pslverr;
    @(posedge hclk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.paddr = a;
    @(posedge hclk); #1;
    apb.penable = 1'b1;
    #1 d = apb.prdata;
    @(posedge hclk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  // device: waits for RTS, clocks up to max_edges pulses (11 = full frame
  // with ACK pulse), captures start..stop bits 1..10 as cap[9:0]
  task automatic dev_xfer(input int max_edges, input logic ack_v, output logic [9:0] cap);
    int t;
    t = 0;
    cap = '0;
    while (!(clk_oe == 1'b0 && dat_oe == 1'b1) && t < 20000) begin
      @(posedge hclk); #1; t++;
    end
    if (t >= 20000) begin
      chk("dev_start_timeout", 32'(t), 32'(0));
      return;
    end
    wait_cyc(HALF);
    for (int i = 0; i < 11 && i < max_edges; i++) begin
      if (i == 10) begin
        dev_dat = ack_v;
        wait_cyc(HALF);
      end
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      if (i < 10) cap[i] = ps2_dat;
      wait_cyc(HALF);
    end
    dev_dat = 1'b1;
  endtask

  initial begin
    logic        err;
    logic [31:0] rdat;
    logic [9:0]  cap;
    int          cnt, first_dat;

    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0;

    // reset state
    wait_cyc(3);
    chk("rst_prdata", apb.prdata, 32'h0);
    chk("rst_pready", 32'(apb.pready), 32'h1);
    chk("rst_pslverr", 32'(apb.pslverr), 32'h0);
    chk("rst_oe", 32'({clk_oe, dat_oe}), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    hrst = 1'b0;
    wait_cyc(2);

    // CTRL and unmapped offset
    apb_write(4'h8, 32'h1, err);
    apb_read(4'h8, rdat);
    chk("ctrl_rd", rdat, 32'h1);
    apb_read(4'hC, rdat);
    chk("unmapped_rd", rdat, 32'h0);

    // 0xED with ACK: inhibit length, RTS position, bits, flags, irq
    apb_write(4'h0, 32'hED, err);
    chk("ed_pslverr", 32'(err), 32'h0);
    cnt = 0; first_dat = 0;
    while (clk_oe && cnt < 20000) begin
      cnt++;
      if (dat_oe && first_dat == 0) first_dat = cnt;
      @(posedge hclk); #1;
    end
    chk("ed_clk_low_cycles", 32'(cnt), 32'(INH + 1));
    chk("ed_rts_cycle", 32'(first_dat), 32'(INH + 1));
    dev_xfer(11, 1'b0, cap);
    chk("ed_bits", 32'(cap), 32'h3ED);
    wait_cyc(10);
    apb_read(4'h4, rdat);
    chk("ed_stat", rdat, 32'h2);
    chk("ed_irq", 32'(irq), 32'h1);
    chk("ed_oe", 32'({clk_oe, dat_oe}), 32'h0);
    apb_write(4'h4, 32'hF, err);
    apb_read(4'h4, rdat);
    chk("ed_stat_clr", rdat, 32'h0);
    wait_cyc(2);
    chk("ed_irq_clr", 32'(irq), 32'h0);

    // 0x01: busy, rejected 0x55 mid-frame, parity 0
    apb_write(4'h0, 32'h01, err);
    apb_read(4'h4, rdat);
    chk("b01_busy", rdat, 32'h1);
    fork
      dev_xfer(11, 1'b0, cap);
      begin
        wait_cyc(INH + 150);
        apb_write(4'h0, 32'h55, err);
        chk("b01_pslverr", 32'(err), 32'h1);
      end
    join
    chk("b01_bits", 32'(cap), 32'h201);
    wait_cyc(10);
    apb_read(4'h4, rdat);
    chk("b01_stat", rdat, 32'h2);
    apb_write(4'h4, 32'hF, err);

    // 0x3C with NACK
    apb_write(4'h0, 32'h3C, err);
    dev_xfer(11, 1'b1, cap);
    chk("nack_bits", 32'(cap), 32'h33C);
    wait_cyc(10);
    apb_read(4'h4, rdat);
    chk("nack_stat", rdat, 32'h6);
    chk("nack_oe", 32'({clk_oe, dat_oe}), 32'h0);
    apb_write(4'h4, 32'hF, err);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    // no device: abort after TMO cycles of SEND
    apb_write(4'h0, 32'h12, err);
    cnt = 0;
    while (clk_oe && cnt < 20000) begin
      cnt++;
      @(posedge hclk); #1;
    end
    wait_cyc(TMO - 2);
    chk("tmo_still_busy", 32'(dat_oe), 32'h1);
    wait_cyc(2);
    chk("tmo_oe", 32'({clk_oe, dat_oe}), 32'h0);
    apb_read(4'h4, rdat);
    chk("tmo_stat", rdat, 32'h8);
    apb_write(4'h4, 32'hF, err);
`endif

    // reset after 4 device edges, then a clean 0xFF
    apb_write(4'h0, 32'hA5, err);
    dev_xfer(4, 1'b0, cap);
    hrst = 1'b1;
    wait_cyc(1);
    chk("mrst_oe", 32'({clk_oe, dat_oe}), 32'h0);
    hrst = 1'b0;
    wait_cyc(1);
    apb_read(4'h4, rdat);
    chk("mrst_stat", rdat, 32'h0);
    apb_read(4'h8, rdat);
    chk("mrst_ctrl", rdat, 32'h0);
    apb_write(4'h0, 32'hFF, err);
    dev_xfer(11, 1'b0, cap);
    chk("ff_bits", 32'(cap), 32'h3FF);
    wait_cyc(10);
    apb_read(4'h4, rdat);
    chk("ff_stat", rdat, 32'h2);
    chk("ff_irq_masked", 32'(irq), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #(2_000_000 * 20);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
